// File: rtl/ascii_pkg.sv
// Shared constants and types for the ASCII character packer.
// WORD_W matches the Hamming encoder's 112-bit data input.
package ascii_pkg;

    localparam int unsigned CHAR_W    = 7;
    localparam int unsigned NUM_CHARS = 16;
    localparam int unsigned WORD_W    = NUM_CHARS * CHAR_W;
    localparam int unsigned CNT_W     = $clog2(NUM_CHARS + 1);
    localparam int unsigned IDX_W     = $clog2(WORD_W);

    localparam logic [CHAR_W-1:0] PAD_CHAR = 7'h20;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    // MSB bit position of slot k; slot 0 sits at the top of the word
    function automatic logic [IDX_W-1:0] slot_msb(input logic [CNT_W-1:0] k);
        return IDX_W'(WORD_W - 1 - (int'(k) % NUM_CHARS) * CHAR_W);
    endfunction

endpackage

// File: rtl/ascii_packer_if.sv
// Character-in / word-out handshake bundle for the ASCII packer.
// slave is the packer side, master is the source/consumer side.
interface ascii_packer_if;
    import ascii_pkg::*;

    logic [CHAR_W-1:0] char_in;
    logic              char_valid;
    logic              char_ready;
    logic              flush;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready;
    logic [CNT_W-1:0]  char_count;

    modport slave (
        input  char_in, char_valid, flush, word_ready,
        output char_ready, word_out, word_valid, char_count
    );

    modport master (
        output char_in, char_valid, flush, word_ready,
        input  char_ready, word_out, word_valid, char_count
    );

endinterface

// File: rtl/ascii_packer.sv
// Packs 7-bit characters MSB-slot-first into a 112-bit word; flush closes a
// partial word by padding the remaining slots with spaces.
module ascii_packer
    import ascii_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    ascii_packer_if.slave bus
);

    state_e             state_q, state_d;
    logic [WORD_W-1:0]  word_q,  word_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               accept_c;
    logic               pad_c;
    logic [IDX_W-1:0]   wr_base_c;

    // Next-state: slot write, optional padding mask, word handshake
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        count_d   = count_q;
        accept_c  = 1'b0;
        pad_c     = 1'b0;
        wr_base_c = slot_msb(count_q);

        case (state_q)
            FILL: begin
                accept_c = bus.char_valid;
                if (accept_c) begin
                    word_d[wr_base_c -: CHAR_W] = bus.char_in;
                    count_d                     = count_q + CNT_W'(1);
                end
                // padding starts after any char accepted this cycle; empty words never close
                pad_c = bus.flush && (count_d != '0);
                if (pad_c) begin
                    for (int unsigned k = 0; k < NUM_CHARS; k++) begin
                        if (CNT_W'(k) >= count_d) begin
                            word_d[WORD_W - 1 - k * CHAR_W -: CHAR_W] = PAD_CHAR;
                        end
                    end
                    count_d = CNT_W'(NUM_CHARS);
                end
                if (count_d == CNT_W'(NUM_CHARS)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.word_ready) begin
                    state_d = FILL;
                    word_d  = '0;
                    count_d = '0;
                end
            end
            default: begin
                state_d = FILL;
                word_d  = '0;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            word_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            count_q <= count_d;
        end
    end

    // Handshake flags decode directly from the state register
    assign bus.char_ready = (state_q == FILL);
    assign bus.word_valid = (state_q == HOLD);
    assign bus.word_out   = word_q;
    assign bus.char_count = count_q;

endmodule

// File: tb/tb_ascii_packer.sv
// Directed bench for ascii_packer: full words, back-pressure, flush corners,
// asynchronous reset mid-word and word/char handshake overlap.
module tb_ascii_packer;
    import ascii_pkg::*;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    ascii_packer_if bus ();

    ascii_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference packing: chars of s in slots 0.., space in the rest
    function automatic logic [WORD_W-1:0] pack_str(input string s);
        logic [WORD_W-1:0] w;
        byte               b;
        w = '0;
        for (int k = 0; k < NUM_CHARS; k++) begin
            if (k < s.len()) begin
                b = s[k];
                w[WORD_W - 1 - k * CHAR_W -: CHAR_W] = b[6:0];
            end else begin
                w[WORD_W - 1 - k * CHAR_W -: CHAR_W] = 7'h20;
            end
        end
        return w;
    endfunction

    task automatic send(input byte c, input logic fl);
        bus.char_in    = c[6:0];
        bus.char_valid = 1'b1;
        bus.flush      = fl;
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
        bus.flush      = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i], 1'b0);
    endtask

    task automatic drain();
        bus.word_ready = 1'b1;
        @(posedge clk); #1;
        bus.word_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.char_in    = '0;
        bus.char_valid = 1'b0;
        bus.flush      = 1'b0;
        bus.word_ready = 1'b0;
        #12;
        n_cmp++;
        if ({bus.char_ready, bus.word_valid, bus.char_count, bus.word_out} !==
            {1'b1, 1'b0, 5'd0, 112'd0}) begin
            $display("FAIL reset_state: rdy=%b vld=%b cnt=%0d word=%h, want rdy=1 vld=0 cnt=0 word=0",
                     bus.char_ready, bus.word_valid, bus.char_count, bus.word_out);
            n_err++;
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        string s = "HAMMINGCODE_TEST";
        send_str(s.substr(0, 14));
        n_cmp++;
        if ({bus.word_valid, bus.char_count} !== {1'b0, 5'd15}) begin
            $display("FAIL full_15chars: vld=%b cnt=%0d, want vld=0 cnt=15", bus.word_valid, bus.char_count);
            n_err++;
        end
        send(s[15], 1'b0);
        n_cmp++;
        if ({bus.word_valid, bus.char_ready, bus.char_count} !== {1'b1, 1'b0, 5'd16}) begin
            $display("FAIL full_flags: vld=%b rdy=%b cnt=%0d, want vld=1 rdy=0 cnt=16",
                     bus.word_valid, bus.char_ready, bus.char_count);
            n_err++;
        end
        n_cmp++;
        if ({bus.word_out[111:105], bus.word_out[6:0]} !== {7'h48, 7'h54}) begin
            $display("FAIL full_ends: slot0=%h slot15=%h, want 48 54", bus.word_out[111:105], bus.word_out[6:0]);
            n_err++;
        end
        n_cmp++;
        if (bus.word_out !== pack_str(s)) begin
            $display("FAIL full_word: got %h want %h", bus.word_out, pack_str(s));
            n_err++;
        end
    endtask

    // Enters already in HOLD; a stray char and flush must both be ignored
    task automatic test_backpressure();
        logic [WORD_W-1:0] w;
        w              = pack_str("HAMMINGCODE_TEST");
        bus.char_in    = 7'h58;
        bus.char_valid = 1'b1;
        bus.flush      = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.char_ready, bus.word_valid, bus.char_count, bus.word_out} !== {1'b0, 1'b1, 5'd16, w}) begin
                $display("FAIL hold_cycle%0d: rdy=%b vld=%b cnt=%0d word=%h, want rdy=0 vld=1 cnt=16 word=%h",
                         c, bus.char_ready, bus.word_valid, bus.char_count, bus.word_out, w);
                n_err++;
            end
        end
        bus.char_valid = 1'b0;
        bus.flush      = 1'b0;
        drain();
        n_cmp++;
        if ({bus.char_ready, bus.word_valid, bus.char_count, bus.word_out} !== {1'b1, 1'b0, 5'd0, 112'd0}) begin
            $display("FAIL after_drain: rdy=%b vld=%b cnt=%0d word=%h, want rdy=1 vld=0 cnt=0 word=0",
                     bus.char_ready, bus.word_valid, bus.char_count, bus.word_out);
            n_err++;
        end
    endtask

    task automatic test_flush_partial();
        send_str("Hi");
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++;
        if ({bus.word_valid, bus.char_count, bus.word_out} !== {1'b1, 5'd16, pack_str("Hi")}) begin
            $display("FAIL flush_partial: vld=%b cnt=%0d word=%h, want vld=1 cnt=16 word=%h",
                     bus.word_valid, bus.char_count, bus.word_out, pack_str("Hi"));
            n_err++;
        end
        n_cmp++;
        if (bus.word_out[111:98] !== {7'h48, 7'h69}) begin
            $display("FAIL flush_head: got %h want %h", bus.word_out[111:98], {7'h48, 7'h69});
            n_err++;
        end
        drain();
    endtask

    task automatic test_flush_with_char();
        send_str("AB");
        send("C", 1'b1);
        n_cmp++;
        if ({bus.word_valid, bus.char_count, bus.word_out} !== {1'b1, 5'd16, pack_str("ABC")}) begin
            $display("FAIL flush_with_char: vld=%b cnt=%0d word=%h, want vld=1 cnt=16 word=%h",
                     bus.word_valid, bus.char_count, bus.word_out, pack_str("ABC"));
            n_err++;
        end
        drain();
    endtask

    task automatic test_flush_empty();
        bus.flush = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++;
        if ({bus.word_valid, bus.char_ready, bus.char_count, bus.word_out} !== {1'b0, 1'b1, 5'd0, 112'd0}) begin
            $display("FAIL flush_empty: vld=%b rdy=%b cnt=%0d word=%h, want vld=0 rdy=1 cnt=0 word=0",
                     bus.word_valid, bus.char_ready, bus.char_count, bus.word_out);
            n_err++;
        end
    endtask

    // Flush alongside the 16th char must not overwrite it with padding
    task automatic test_flush_last_char();
        string s = "ABCDEFGHIJKLMNOP";
        send_str(s.substr(0, 14));
        send(s[15], 1'b1);
        n_cmp++;
        if ({bus.word_valid, bus.char_count, bus.word_out} !== {1'b1, 5'd16, pack_str(s)}) begin
            $display("FAIL flush_last_char: vld=%b cnt=%0d word=%h, want vld=1 cnt=16 word=%h",
                     bus.word_valid, bus.char_count, bus.word_out, pack_str(s));
            n_err++;
        end
        drain();
    endtask

    task automatic test_reset_mid();
        string s = "0123456789abcdef";
        send_str("partial");
        n_cmp++;
        if (bus.char_count !== 5'd7) begin
            $display("FAIL pre_reset_count: got %0d want 7", bus.char_count);
            n_err++;
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.word_valid, bus.char_count, bus.word_out} !== {1'b0, 5'd0, 112'd0}) begin
            $display("FAIL async_reset: vld=%b cnt=%0d word=%h, want vld=0 cnt=0 word=0",
                     bus.word_valid, bus.char_count, bus.word_out);
            n_err++;
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        send_str(s);
        n_cmp++;
        if ({bus.word_valid, bus.char_count, bus.word_out} !== {1'b1, 5'd16, pack_str(s)}) begin
            $display("FAIL clean_after_reset: vld=%b cnt=%0d word=%h, want vld=1 cnt=16 word=%h",
                     bus.word_valid, bus.char_count, bus.word_out, pack_str(s));
            n_err++;
        end
    endtask

    // Enters in HOLD; 'Z' offered across the word handshake lands once in slot 0
    task automatic test_simultaneous();
        logic [WORD_W-1:0] exp_w;
        exp_w                          = '0;
        exp_w[WORD_W-1 -: CHAR_W]      = 7'h5A;
        bus.char_in    = 7'h5A;
        bus.char_valid = 1'b1;
        bus.word_ready = 1'b1;
        @(posedge clk); #1;
        bus.word_ready = 1'b0;
        n_cmp++;
        if ({bus.word_valid, bus.char_ready, bus.char_count, bus.word_out} !== {1'b0, 1'b1, 5'd0, 112'd0}) begin
            $display("FAIL turnaround: vld=%b rdy=%b cnt=%0d word=%h, want vld=0 rdy=1 cnt=0 word=0",
                     bus.word_valid, bus.char_ready, bus.char_count, bus.word_out);
            n_err++;
        end
        @(posedge clk); #1;
        bus.char_valid = 1'b0;
        n_cmp++;
        if ({bus.char_count, bus.word_out} !== {5'd1, exp_w}) begin
            $display("FAIL held_char_taken: cnt=%0d word=%h, want cnt=1 word=%h",
                     bus.char_count, bus.word_out, exp_w);
            n_err++;
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.char_count !== 5'd1) begin
            $display("FAIL held_char_once: got %0d want 1", bus.char_count);
            n_err++;
        end
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        n_cmp++;
        if ({bus.word_valid, bus.word_out} !== {1'b1, pack_str("Z")}) begin
            $display("FAIL flush_after_turnaround: vld=%b word=%h, want vld=1 word=%h",
                     bus.word_valid, bus.word_out, pack_str("Z"));
            n_err++;
        end
        drain();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_full_word();
        test_backpressure();
        test_flush_partial();
        test_flush_with_char();
        test_flush_empty();
        test_flush_last_char();
        test_reset_mid();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
